board_painter: RTL and testbench
================================

// Module: board_painter
// PURPOSE
// - Parametrised VGA renderer for the GRID_N x GRID_N tile board; successor to the fixed 4x4 painter.
// - Sits between the VGA sync generator (hs/vs pixel counters) and the DAC outputs.
// - Tracks tile column/row incrementally (no dividers) and maps each tile's state code through a palette.
// - Adds a 2-stage registered pixel pipeline and a frame-synchronous blinking win/lose overlay.
// PARAMETERS
// - GRID_N       4    tiles per row and per column
// - STATE_W      4    bits per tile state code
// - CELL_W       154  tile interior width, pixels
// - CELL_H       113  tile interior height, pixels
// - LINE_W       4    grid line thickness, pixels (both axes)
// - H_ACTIVE     640  visible pixels per line
// - V_ACTIVE     480  visible lines per frame
// - BLINK_FRAMES 30   frames per overlay blink half-period (>=1)
// PORTS
// - clk     in   1                        pixel-domain clock
// - reset   in   1                        async, active-low
// - hs      in   10                       current pixel column from sync generator
// - vs      in   10                       current pixel row from sync generator
// - states  in   GRID_N*GRID_N*STATE_W    tile codes; tile k = states[k*STATE_W +: STATE_W], k = row*GRID_N+col
// - win     in   1                        game won (level)
// - lose    in   1                        game lost (level)
// - r,g,b   out  8 each                   pixel colour
// BEHAVIOUR
// - Reset (reset=0, async): r,g,b=0; all counters 0; overlay mode NONE; blink_on=1.
// - Geometry: pitch_x=CELL_W+LINE_W, pitch_y=CELL_H+LINE_W; board spans [0, GRID_N*pitch_x+LINE_W) x [0, GRID_N*pitch_y+LINE_W).
// - A pixel is LINE if its offset within pitch is < LINE_W on either axis, or it lies in the closing line (last LINE_W px of the board).
// - Column tracking: hs==0 -> col_idx=0, col_off=0; hs==hs_prev+1 -> col_off++, wraps to 0 at pitch_x with col_idx++ (saturates at GRID_N); any other hs -> hold.
// - Row tracking: same rule on vs, evaluated only when vs changes; vs==0 clears.
// - Stage 1 registers: in_active (hs<H_ACTIVE && vs<V_ACTIVE), in_board, is_line, tile index, selected tile code.
// - Stage 2 registers r,g,b. Latency: hs/vs sampled at edge N -> colour valid after edge N+2.
// - Colour priority: !in_active -> 000000; !in_board -> 000000; is_line -> BBADA0;
//   overlay shown on tile -> WIN 00C000 / LOSE C00000; otherwise palette.
// - Palette: code 0 CDC1B4; 1 EEE4DA; 2 EDE0C8; 3 F2B179; 4 F59563; 5 F67C5F; 6 F65E3B; 7 EDCF72;
//   8 EDCC61; 9 EDC850; 10 EDC53F; 11 EDC22E; >=12 3C3A32.
// - Frame start = vs transitions to 0. At frame start: overlay mode latched (win -> WIN, else lose -> LOSE, else NONE);
//   frame counter increments; at BLINK_FRAMES it wraps to 0 and blink_on toggles.
// - win/lose changes mid-frame take effect only at next frame start (no tearing). win && lose -> WIN.
// - Overlay shown on a tile iff mode!=NONE && blink_on; lines and background are never overlaid.
// - Mode returning to NONE: frame counter clears, blink_on=1.
// - hs held constant (pixel-enable low): counters hold; output repeats same colour.
// - Reset mid-frame: outputs 0 immediately; tracking resumes correctly from the next hs==0.
// TESTING
// - Reset mid-line with hs=300,vs=200 -> r,g,b=0 same cycle; release, sweep from hs=0,vs=0 -> first colour 2 clk later.
// - All states=0, pixel (hs=2,vs=2) -> BBADA0; (hs=10,vs=10) -> CDC1B4, both at input+2 clk.
// - states tile5=11, pixel (hs=170,vs=125) -> EDC22E; tile5=15 -> 3C3A32; (hs=636,vs=10) -> 000000.
// - hs=640..799 blanking with any states -> 000000; hs stalled 3 clk at 50 -> 3 identical colours, col_idx unchanged.
// - win raised at vs=200 -> unchanged until next vs=0; then tiles 00C000 for 30 frames, palette 30 frames, repeat; lines stay BBADA0.
// - win=1,lose=1 -> 00C000 overlay; lose only -> C00000; drop both -> palette from next frame, blink_on=1.

Source files
------------

// File: rtl/board_painter.sv
// GRID_N x GRID_N tile board renderer: incremental tile tracking from hs/vs, palette lookup,
// two registered pixel stages and a frame-synchronous blinking win/lose overlay.

module board_painter_axis #(
    parameter int PITCH = 158,
    parameter int LIMIT = 4,
    parameter int OFF_W = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [9:0]       pos,
    output logic [9:0]       pos_q,
    output logic [IDX_W-1:0] idx,
    output logic [OFF_W-1:0] off
);
    // Only a +1 step advances the position; stalls and jumps hold, 0 restarts the axis.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pos_q <= '0;
            idx   <= '0;
            off   <= '0;
        end else begin
            pos_q <= pos;
            if (pos == 10'd0) begin
                idx <= '0;
                off <= '0;
            end else if ({1'b0, pos} == {1'b0, pos_q} + 11'd1) begin
                if (off == OFF_W'(PITCH - 1)) begin
                    off <= '0;
                    if (idx != IDX_W'(LIMIT))
                        idx <= idx + 1'b1;
                end else begin
                    off <= off + 1'b1;
                end
            end
        end
    end
endmodule

module board_painter #(
    parameter int GRID_N       = 4,
    parameter int STATE_W      = 4,
    parameter int CELL_W       = 154,
    parameter int CELL_H       = 113,
    parameter int LINE_W       = 4,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [9:0]                        hs,
    input  logic [9:0]                        vs,
    input  logic [GRID_N*GRID_N*STATE_W-1:0]  states,
    input  logic                              win,
    input  logic                              lose,
    output logic [7:0]                        r,
    output logic [7:0]                        g,
    output logic [7:0]                        b
);
    localparam int PITCH_X = CELL_W + LINE_W;
    localparam int PITCH_Y = CELL_H + LINE_W;
    localparam int BOARD_W = GRID_N * PITCH_X + LINE_W;
    localparam int BOARD_H = GRID_N * PITCH_Y + LINE_W;
    localparam int OFFX_W  = $clog2(PITCH_X);
    localparam int OFFY_W  = $clog2(PITCH_Y);
    localparam int IDX_W   = $clog2(GRID_N + 1);
    localparam int TILE_W  = (GRID_N > 1) ? $clog2(GRID_N * GRID_N) : 1;
    localparam int CNT_W   = $clog2(BLINK_FRAMES + 1);

    localparam logic [23:0] LINE_RGB = 24'hBBADA0;
    localparam logic [23:0] WIN_RGB  = 24'h00C000;
    localparam logic [23:0] LOSE_RGB = 24'hC00000;

    typedef enum logic [1:0] {MODE_NONE, MODE_WIN, MODE_LOSE} mode_t;

    typedef struct packed {
        logic               in_active;
        logic               in_board;
        logic               is_line;
        logic               show_ovl;
        logic               ovl_win;
        logic [STATE_W-1:0] code;
    } px_t;

    function automatic logic [23:0] palette(input logic [STATE_W-1:0] code);
        case (int'(code))
            0:       return 24'hCDC1B4;
            1:       return 24'hEEE4DA;
            2:       return 24'hEDE0C8;
            3:       return 24'hF2B179;
            4:       return 24'hF59563;
            5:       return 24'hF67C5F;
            6:       return 24'hF65E3B;
            7:       return 24'hEDCF72;
            8:       return 24'hEDCC61;
            9:       return 24'hEDC850;
            10:      return 24'hEDC53F;
            11:      return 24'hEDC22E;
            default: return 24'h3C3A32;
        endcase
    endfunction

    logic [9:0]                       hs_q, vs_q;
    logic [IDX_W-1:0]                 col_idx, row_idx, col_c, row_c;
    logic [OFFX_W-1:0]                col_off;
    logic [OFFY_W-1:0]                row_off;
    logic [TILE_W-1:0]                tile_c;
    logic [GRID_N*GRID_N*STATE_W-1:0] states_q;
    mode_t                            mode, next_mode;
    logic [CNT_W-1:0]                 frame_cnt;
    logic                             blink_on, frame_start;
    px_t                              px_d, px_q;
    logic [23:0]                      colour, rgb_q;

    board_painter_axis #(.PITCH(PITCH_X), .LIMIT(GRID_N), .OFF_W(OFFX_W), .IDX_W(IDX_W)) u_col (
        .clk(clk), .reset(reset), .pos(hs), .pos_q(hs_q), .idx(col_idx), .off(col_off)
    );

    board_painter_axis #(.PITCH(PITCH_Y), .LIMIT(GRID_N), .OFF_W(OFFY_W), .IDX_W(IDX_W)) u_row (
        .clk(clk), .reset(reset), .pos(vs), .pos_q(vs_q), .idx(row_idx), .off(row_off)
    );

    assign frame_start = (vs == 10'd0) && (vs_q != 10'd0);

    always_comb begin
        next_mode = MODE_NONE;
        if (win)
            next_mode = MODE_WIN;
        else if (lose)
            next_mode = MODE_LOSE;
    end

    // Overlay state only moves at frame start so a mid-frame win/lose never tears the picture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode      <= MODE_NONE;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            states_q  <= '0;
        end else begin
            states_q <= states;
            if (frame_start) begin
                mode <= next_mode;
                if (next_mode == MODE_NONE || mode == MODE_NONE) begin
                    frame_cnt <= '0;
                    blink_on  <= 1'b1;
                end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    blink_on  <= ~blink_on;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Past the last tile the index sits at GRID_N; clamp it, that region is always line or off-board.
    always_comb begin
        col_c = (col_idx >= IDX_W'(GRID_N)) ? IDX_W'(GRID_N - 1) : col_idx;
        row_c = (row_idx >= IDX_W'(GRID_N)) ? IDX_W'(GRID_N - 1) : row_idx;
        tile_c = TILE_W'(int'(row_c) * GRID_N + int'(col_c));
        px_d.in_active = ({1'b0, hs_q} < 11'(H_ACTIVE)) && ({1'b0, vs_q} < 11'(V_ACTIVE));
        px_d.in_board  = ({1'b0, hs_q} < 11'(BOARD_W))  && ({1'b0, vs_q} < 11'(BOARD_H));
        px_d.is_line   = (col_off < OFFX_W'(LINE_W)) || (row_off < OFFY_W'(LINE_W));
        px_d.show_ovl  = (mode != MODE_NONE) && blink_on;
        px_d.ovl_win   = (mode == MODE_WIN);
        px_d.code      = states_q[tile_c*STATE_W +: STATE_W];
    end

    always_comb begin
        colour = 24'h000000;
        if (px_q.in_active && px_q.in_board) begin
            if (px_q.is_line)
                colour = LINE_RGB;
            else if (px_q.show_ovl)
                colour = px_q.ovl_win ? WIN_RGB : LOSE_RGB;
            else
                colour = palette(px_q.code);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            px_q  <= '0;
            rgb_q <= '0;
        end else begin
            px_q  <= px_d;
            rgb_q <= colour;
        end
    end

    assign {r, g, b} = rgb_q;
endmodule

// File: tb/tb_board_painter.sv
// Randomised sweeps of board_painter checked by a scoreboard against a geometric model of the board.

module tb_board_painter;
    localparam int GN = 4, SW = 4, PX = 158, PY = 117, LW = 4;
    localparam int BW = GN * PX + LW, BH = GN * PY + LW, BF = 30;
    localparam int STW = GN * GN * SW;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [9:0]      hs, vs;
    logic [STW-1:0]  states;
    logic            win, lose;
    logic [7:0]      r, g, b;

    board_painter dut (
        .clk(clk), .reset(reset), .hs(hs), .vs(vs), .states(states),
        .win(win), .lose(lose), .r(r), .g(g), .b(b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        int          h;
        int          v;
    } exp_t;

    exp_t           q[$];
    int             cyc = 0;
    int             n_checks = 0, n_fail = 0;
    logic [STW-1:0] nx_states;
    logic           nx_win, nx_lose;

    // model state: logical pixel position per axis, overlay mode, frames since overlay began
    int m_hp, m_vp, m_xp, m_yp, m_mode, m_fss;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pal(input int c);
        case (c)
            0: return 24'hCDC1B4;  1: return 24'hEEE4DA;  2: return 24'hEDE0C8;
            3: return 24'hF2B179;  4: return 24'hF59563;  5: return 24'hF67C5F;
            6: return 24'hF65E3B;  7: return 24'hEDCF72;  8: return 24'hEDCC61;
            9: return 24'hEDC850; 10: return 24'hEDC53F; 11: return 24'hEDC22E;
            default: return 24'h3C3A32;
        endcase
    endfunction

    task automatic model_reset();
        m_hp = 0; m_vp = 0; m_xp = 0; m_yp = 0; m_mode = 0; m_fss = 0;
    endtask

    task automatic model_step(input int h, input int v, input logic [STW-1:0] st,
                              input logic w, input logic l, output logic [23:0] rgb);
        int nm, cx, ry, k;
        if (h == 0) m_xp = 0; else if (h == m_hp + 1) m_xp++;
        if (v == 0) m_yp = 0; else if (v == m_vp + 1) m_yp++;
        if (v == 0 && m_vp != 0) begin
            nm = w ? 1 : (l ? 2 : 0);
            if (nm == 0 || m_mode == 0) m_fss = 0; else m_fss++;
            m_mode = nm;
        end
        m_hp = h; m_vp = v;
        cx = (m_xp / PX > GN - 1) ? GN - 1 : m_xp / PX;
        ry = (m_yp / PY > GN - 1) ? GN - 1 : m_yp / PY;
        k = ry * GN + cx;
        if (!(h < 640 && v < 480) || !(h < BW && v < BH)) rgb = 24'h000000;
        else if ((m_xp % PX) < LW || (m_yp % PY) < LW) rgb = 24'hBBADA0;
        else if (m_mode != 0 && ((m_fss / BF) % 2 == 0)) rgb = (m_mode == 1) ? 24'h00C000 : 24'hC00000;
        else rgb = pal(int'(st[k*SW +: SW]));
    endtask

    task automatic drive(input int h, input int v);
        exp_t e;
        @(negedge clk);
        hs = h[9:0]; vs = v[9:0]; states = nx_states; win = nx_win; lose = nx_lose;
        model_step(h, v, nx_states, nx_win, nx_lose, e.rgb);
        e.due = cyc + 3; e.h = h; e.v = v;
        q.push_back(e);
    endtask

    task automatic line(input int v, input int hmax);
        for (int h = 0; h <= hmax; h++) begin
            drive(h, v);
            if ($urandom_range(7) == 0) repeat ($urandom_range(3, 1)) drive(h, v);
        end
    endtask

    task automatic full_line(input int v);
        int h;
        h = 0;
        while (h < 800) begin
            drive(h, v);
            if (h == 50) begin drive(h, v); drive(h, v); end
            else if ($urandom_range(15) == 0) drive(h, v);
            h = (h == 700) ? 760 : h + 1;
        end
    endtask

    function automatic logic [STW-1:0] rand_states(input int t5);
        logic [STW-1:0] s;
        for (int k = 0; k < GN * GN; k++) s[k*SW +: SW] = SW'($urandom_range(15));
        s[5*SW +: SW] = SW'(t5);
        return s;
    endfunction

    // Monitor: reset must blank the outputs immediately; otherwise pop every due expectation.
    always @(posedge clk or negedge reset) begin : mon
        exp_t e;
        if (!reset) begin
            #1;
            n_checks++;
            if ({r, g, b} !== 24'h000000) begin
                n_fail++;
                $display("FAIL reset_rgb: got %06h want 000000", {r, g, b});
            end
            q.delete();
        end else begin
            #2;
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                n_checks++;
                if ({r, g, b} !== e.rgb) begin
                    n_fail++;
                    $display("FAIL pixel hs=%0d vs=%0d: got %06h want %06h", e.h, e.v, {r, g, b}, e.rgb);
                end
            end
        end
    end

    initial begin
        hs = '0; vs = '0; states = '0; win = 1'b0; lose = 1'b0;
        nx_states = '0; nx_win = 1'b0; nx_lose = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // empty board: grid lines and code-0 tiles
        for (int v = 0; v <= 12; v++) line(v, 12);

        // random boards with tile 5 pinned, full lines through it, then reset mid-line
        nx_states = rand_states(11);
        for (int v = 0; v <= 200; v++) begin
            if (v % 16 == 0) nx_states = rand_states(v >= 126 ? 15 : 11);
            if (v == 125) full_line(v);
            else if (v == 126) begin nx_states = rand_states(15); full_line(v); end
            else if (v == 200) line(v, 299);
            else line(v, 15);
        end
        @(negedge clk);
        hs = 10'd300; vs = 10'd200; reset = 1'b0;
        repeat (2) @(negedge clk);
        hs = '0; vs = '0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // tall frame down into vertical blanking
        nx_states = rand_states(int'($urandom_range(15)));
        for (int v = 0; v <= 520; v++) begin
            if (v == 470) line(v, 700); else line(v, 8);
        end

        // short frames exercising the overlay and its blink period
        for (int f = 0; f < 89; f++) begin
            int  sw;
            logic w, l;
            sw = int'($urandom_range(10));
            if (f < 2)       begin w = 1'b0; l = 1'b0; end
            else if (f < 66) begin w = 1'b1; l = 1'b0; if (f == 2) sw = 5; end
            else if (f < 71) begin w = 1'b1; l = 1'b1; end
            else if (f < 77) begin w = 1'b0; l = 1'b1; end
            else if (f < 81) begin w = 1'b0; l = 1'b0; end
            else begin w = 1'($urandom_range(1)); l = 1'($urandom_range(1)); end
            nx_states = rand_states(int'($urandom_range(15)));
            for (int v = 0; v <= 10; v++) begin
                if (v == sw) begin nx_win = w; nx_lose = l; end
                line(v, 11);
            end
        end

        repeat (6) @(negedge clk);
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected pixels never presented, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
